// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver.
//
// Segment vectors are active-low with bit 0 = segment a ... bit 6 = segment g,
// matching the board Ca..Cg pin order.
//   SEG_HEX   : glyphs for 0-F (index = nibble value)
//   SEG_BLANK : all segments dark
//   SEG_DASH  : segment g only
//   clog2     : ceiling log2 usable in parameter expressions
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Packed so SEG_HEX[nibble] selects one 7-bit glyph; listed F down to 0.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    StIdle,
    StHexCopy,
    StConv
  } ctrl_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
//
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   start_i      : load din_i and begin (only honoured when idle)
//   din_i        : binary input
//   busy_o       : high for exactly VALUE_W cycles after the start edge
//   done_o       : one-cycle pulse after the last shift; bcd_o valid from then
//   bcd_o        : BCD_DIGITS packed BCD digits, digit 0 in bits [3:0]
module bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int unsigned VALUE_W    = 16,
  parameter int unsigned BCD_DIGITS = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      din_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);

  localparam int unsigned CntW = clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]      sh_q, sh_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_comb begin
    // Add-3 correction on every digit >= 5 before the shift.
    bcd_adj = bcd_q;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (bcd_q[4*d+:4] >= 4'd5) bcd_adj[4*d+:4] = bcd_q[4*d+:4] + 4'd3;
    end

    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start_i && !busy_q) begin
      sh_d   = din_i;
      bcd_d  = '0;
      cnt_d  = CntW'(VALUE_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, sh_d} = {bcd_adj[4*BCD_DIGITS-2:0], sh_q, 1'b0};
      cnt_d         = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/ssd_scan_mux.sv
// Multiplexed common-anode seven-segment driver with hex/decimal display,
// leading-zero blanking, per-digit decimal points and decimal overflow dashes.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   value       : binary number to display
//   hex_mode    : 1 = hexadecimal, 0 = decimal (sequential BCD conversion)
//   blank_lz    : 1 = blank leading zero digits (digit 0 never blanked)
//   dp_mask     : per-digit decimal point enable
//   enable      : 0 = all anodes off, scan frozen (conversion still runs)
//   brightness  : duty control, present only with SSD_DIMMING_EN defined
//   anode       : active-low digit selects, bit 0 = least-significant digit
//   seg         : active-low segments, bit 0 = a ... bit 6 = g
//   dp          : active-low decimal point
//   conv_busy   : decimal conversion in progress
//
// Build option: define SSD_DIMMING_EN to add the brightness input; otherwise
// each digit is lit for its whole slot.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned VALUE_W        = 16,
  parameter int unsigned REFRESH_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  enable,
`ifdef SSD_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  conv_busy
);

  localparam int unsigned BCD_DIGITS = (VALUE_W * 3) / 10 + 1;
  localparam int unsigned DispW      = 4 * NUM_DIGITS;
  localparam int unsigned CntW       = clog2(REFRESH_CYCLES);
  localparam int unsigned IdxW       = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

  ctrl_state_e             state_q, state_d;
  logic [VALUE_W-1:0]      val_q, val_d;
  logic                    hex_q, hex_d;
  logic [DispW-1:0]        disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    conv_start;
  logic                    conv_done;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [3:0]              cur_digit;
  logic                    upper_zero;
  logic                    lit;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (conv_start),
    .din_i   (value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  // Capture / display-register update. Inputs are only compared while idle, so a
  // change during conversion is picked up by the first compare after commit.
  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    hex_d      = hex_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;

    case (state_q)
      StIdle: begin
        if ((value != val_q) || (hex_mode != hex_q)) begin
          val_d = value;
          hex_d = hex_mode;
          if (hex_mode) begin
            state_d = StHexCopy;
          end else begin
            // Converter loads straight from the input so busy starts this edge.
            conv_start = 1'b1;
            state_d    = StConv;
          end
        end
      end
      StHexCopy: begin
        // Shifting past VALUE_W yields zero for nibbles above the hex width.
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          disp_d[4*i+:4] = 4'(val_q >> (4 * i));
        end
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
      StConv: begin
        if (conv_done) begin
          for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            disp_d[4*i+:4] = 4'(bcd >> (4 * i));
          end
          ovf_d   = |(bcd >> DispW);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SSD_DIMMING_EN
  logic [31:0] on_cycles;
  always_comb begin
    on_cycles = ((32'(brightness) + 32'd1) * 32'(REFRESH_CYCLES)) >> 4;
    lit       = 32'(cnt_q) < on_cycles;
  end
`else
  assign lit = 1'b1;
`endif

  // Scan timing and registered digit outputs.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) begin
      if (cnt_q == CntW'(REFRESH_CYCLES - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    cur_digit  = disp_q[4*idx_q+:4];
    // Digits idx..NUM_DIGITS-1 are all zero.
    upper_zero = ((disp_q >> (4 * idx_q)) == '0);

    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_lz && (idx_q != '0) && upper_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = SEG_HEX[cur_digit];
    end

    anode_d = '1;
    if (enable && lit) anode_d[idx_q] = 1'b0;
    dp_d = ~dp_mask[idx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      val_q   <= '0;
      hex_q   <= 1'b1;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      hex_q   <= hex_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode = anode_q;
  assign seg   = seg_q;
  assign dp    = dp_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Self-checking bench for ssd_scan_mux (4 digits, 16-bit value, 4-cycle slots).
module tb_ssd_scan_mux;

  localparam int N = 4;
  localparam int W = 16;
  localparam int R = 4;

  // Expected glyphs, active-low, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] value;
  logic         hex_mode;
  logic         blank_lz;
  logic [N-1:0] dp_mask;
  logic         enable;
  logic [N-1:0] anode;
  logic [6:0]   seg;
  logic         dp;
  logic         conv_busy;

  int checks = 0;
  int errors = 0;

  ssd_scan_mux #(
    .NUM_DIGITS     (N),
    .VALUE_W        (W),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .dp_mask   (dp_mask),
    .enable    (enable),
`ifdef SSD_DIMMING_EN
    .brightness(4'hF),
`endif
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .conv_busy (conv_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Digit i as the display should show it, from plain positional arithmetic.
  function automatic logic [6:0] model_seg(input int v, input bit hx, input bit blz, input int i);
    int base, p, span;
    base = hx ? 16 : 10;
    if (!hx && v >= 10000) return 7'h3F;
    p = 1;
    for (int k = 0; k < i; k++) p = p * base;
    span = 1;
    for (int k = 0; k < N - i; k++) span = span * base;
    if (blz && i > 0 && ((v / p) % span) == 0) return 7'h7F;
    return SEG_TAB[(v / p) % base];
  endfunction

  function automatic int anode_idx(input logic [N-1:0] a);
    int r, n;
    r = -1;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (a[i] === 1'b0) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  task automatic seg_now(input string tag, input int v, input bit hx, input bit blz);
    int idx;
    idx = anode_idx(anode);
    check_eq({tag, "_onehot"}, 32'(idx >= 0), 1);
    if (idx >= 0) check_eq({tag, "_seg"}, 32'(seg), 32'(model_seg(v, hx, blz, idx)));
  endtask

  // One full scan period: one-hot anode, glyph, dp, rotation order, dwell.
  task automatic scan_check(input string tag, input int v, input bit hx, input bit blz);
    int seen[N];
    int prev, idx;
    prev = -1;
    for (int i = 0; i < N; i++) seen[i] = 0;
    repeat (N * R) begin
      @(negedge clk);
      idx = anode_idx(anode);
      check_eq({tag, "_onehot"}, 32'(idx >= 0), 1);
      if (idx >= 0) begin
        check_eq($sformatf("%s_seg%0d", tag, idx), 32'(seg), 32'(model_seg(v, hx, blz, idx)));
        check_eq($sformatf("%s_dp%0d", tag, idx), 32'(dp), 32'(!dp_mask[idx]));
        if (prev >= 0 && idx != prev) check_eq({tag, "_order"}, idx, (prev + 1) % N);
        seen[idx]++;
        prev = idx;
      end
    end
    for (int i = 0; i < N; i++) check_eq($sformatf("%s_dwell%0d", tag, i), seen[i], R);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_before, idx_after, exp_busy, v;

    reset    = 1'b1;
    value    = '0;
    hex_mode = 1'b1;
    blank_lz = 1'b0;
    dp_mask  = '0;
    enable   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_anode", 32'(anode), 32'hF);
    check_eq("rst_seg", 32'(seg), 32'h7F);
    check_eq("rst_dp", 32'(dp), 1);
    check_eq("rst_busy", 32'(conv_busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rel_digit0", 32'(anode), 32'hE);
    scan_check("zero", 0, 1'b1, 1'b0);

    // Hex: display register two edges after the change, output one edge later.
    value = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    seg_now("hex_old", 0, 1'b1, 1'b0);
    @(negedge clk);
    seg_now("hex_new", 16'hBEEF, 1'b1, 1'b0);
    scan_check("beef", 16'hBEEF, 1'b1, 1'b0);

    // Decimal 1234, switched to 42 during busy cycle 5.
    value    = 16'd1234;
    hex_mode = 1'b0;
    check_eq("busy_pre", 32'(conv_busy), 0);
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      exp_busy = ((k >= 1 && k <= 16) || (k >= 19 && k <= 34)) ? 1 : 0;
      check_eq($sformatf("busy_k%0d", k), 32'(conv_busy), exp_busy);
      if (k == 5) value = 16'd42;
      if (k == 18) seg_now("dec_old", 16'hBEEF, 1'b1, 1'b0);
      if (k == 19) seg_now("dec_1234", 1234, 1'b0, 1'b0);
      if (k == 36) seg_now("dec_still1234", 1234, 1'b0, 1'b0);
      if (k == 37) seg_now("dec_42", 42, 1'b0, 1'b0);
    end
    scan_check("dec42", 42, 1'b0, 1'b0);

    value = 16'd9999;
    repeat (25) @(negedge clk);
    scan_check("d9999", 9999, 1'b0, 1'b0);
    value = 16'd10000;
    repeat (25) @(negedge clk);
    scan_check("d10000", 10000, 1'b0, 1'b0);
    value = 16'd65535;
    repeat (25) @(negedge clk);
    scan_check("ovf", 65535, 1'b0, 1'b0);

    value    = 16'd7;
    blank_lz = 1'b1;
    dp_mask  = 4'b0010;
    repeat (25) @(negedge clk);
    scan_check("blank7", 7, 1'b0, 1'b1);

    // Disable: anodes dark, index frozen, conversion keeps going.
    idx_before = anode_idx(anode);
    enable     = 1'b0;
    value      = 16'd555;
    blank_lz   = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check_eq($sformatf("dis_anode%0d", k), 32'(anode), 32'hF);
    end
    enable = 1'b1;
    @(negedge clk);
    idx_after = anode_idx(anode);
    check_eq("dis_resume", 32'(idx_before >= 0 &&
             (idx_after == idx_before || idx_after == (idx_before + 1) % N)), 1);
    seg_now("dis_conv", 555, 1'b0, 1'b0);
    scan_check("d555", 555, 1'b0, 1'b0);

    // Reset in the middle of a conversion.
    value = 16'd3210;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_anode", 32'(anode), 32'hF);
    check_eq("mid_rst_seg", 32'(seg), 32'h7F);
    check_eq("mid_rst_dp", 32'(dp), 1);
    check_eq("mid_rst_busy", 32'(conv_busy), 0);
    value    = '0;
    hex_mode = 1'b1;
    dp_mask  = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rel_digit0", 32'(anode), 32'hE);
    scan_check("mid_zero", 0, 1'b1, 1'b0);

    for (int it = 0; it < 20; it++) begin
      case ($urandom % 3)
        0:       v = int'($urandom % 65536);
        1:       v = int'($urandom % 100);
        default: v = int'($urandom % 4096);
      endcase
      value    = W'(v);
      hex_mode = 1'($urandom);
      blank_lz = 1'($urandom);
      dp_mask  = N'($urandom);
      repeat (40) @(negedge clk);
      scan_check($sformatf("rnd%0d", it), v, hex_mode, blank_lz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
